// File: rtl/booth_divider.sv
// Sequential signed divider: restoring division on magnitudes,
// one quotient bit per clock, then sign correction.
module booth_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN_V =
    {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE, S_CALC, S_FIX, S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic             sq_q, sq_d;
  logic             sr_q, sr_d;
  logic             dbz_p_q, dbz_p_d;
  logic             ovf_p_q, ovf_p_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rmd_q, rmd_d;
  logic             dbz_q, dbz_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0] dvd_mag, dsr_mag;
  logic [WIDTH:0]   shifted, trial;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      acc_q   <= '0;
      dsr_q   <= '0;
      sq_q    <= 1'b0;
      sr_q    <= 1'b0;
      dbz_p_q <= 1'b0;
      ovf_p_q <= 1'b0;
      quo_q   <= '0;
      rmd_q   <= '0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      acc_q   <= acc_d;
      dsr_q   <= dsr_d;
      sq_q    <= sq_d;
      sr_q    <= sr_d;
      dbz_p_q <= dbz_p_d;
      ovf_p_q <= ovf_p_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start) state_d = S_CALC;
      S_CALC: if (cnt_q == CW'(1)) state_d = S_FIX;
      S_FIX:  state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ready       = (state_q == S_IDLE);
    done        = (state_q == S_DONE);
    quotient    = quo_q;
    remainder   = rmd_q;
    div_by_zero = dbz_q;
    overflow    = ovf_q;
  end

  // acc_q starts as the dividend magnitude and fills with quotient bits
  always_comb begin
    dvd_mag = dividend[WIDTH-1] ? -dividend : dividend;
    dsr_mag = divisor[WIDTH-1] ? -divisor : divisor;
    shifted = {rem_q[WIDTH-1:0], acc_q[WIDTH-1]};
    trial   = shifted - {1'b0, dsr_q};

    cnt_d   = cnt_q;
    rem_d   = rem_q;
    acc_d   = acc_q;
    dsr_d   = dsr_q;
    sq_d    = sq_q;
    sr_d    = sr_q;
    dbz_p_d = dbz_p_q;
    ovf_p_d = ovf_p_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          sq_d    = dividend[WIDTH-1] ^ divisor[WIDTH-1];
          sr_d    = dividend[WIDTH-1];
          acc_d   = dvd_mag;
          dsr_d   = dsr_mag;
          rem_d   = '0;
          cnt_d   = CW'(WIDTH);
          dbz_p_d = (divisor == '0);
          ovf_p_d = (dividend == MIN_V)
                 && (divisor == '1);
        end
      end
      S_CALC: begin
        cnt_d = cnt_q - CW'(1);
        if (!trial[WIDTH]) begin
          rem_d = trial;
          acc_d = {acc_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = shifted;
          acc_d = {acc_q[WIDTH-2:0], 1'b0};
        end
      end
      S_FIX: begin
        // a zero divisor leaves |dividend| in rem_q
        if (dbz_p_q)   quo_d = '1;
        else if (sq_q) quo_d = -acc_q;
        else           quo_d = acc_q;
        rmd_d = sr_q ? -rem_q[WIDTH-1:0]
                     : rem_q[WIDTH-1:0];
        dbz_d = dbz_p_q;
        ovf_d = ovf_p_q;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/booth_divider.md
Name: booth_divider

Overview:
- Sequential signed integer divider; the inverse companion of the team's signed 8x8 Booth multiplier.
- Computes quotient and remainder of two's-complement operands, one quotient bit per clock, using restoring division on operand magnitudes followed by sign correction.
- Sits beside the multiplier in the arithmetic datapath.
- Uses a start/ready/done handshake so a controller can issue one division at a time.

Parameters:
- WIDTH, 8, operand/result width in bits (signed two's complement); legal range 4..32.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only when ready=1.
- dividend  input  WIDTH  signed dividend; captured on accepted start.
- divisor  input  WIDTH  signed divisor; captured on accepted start.
- ready  output  1  high only in IDLE; block can accept start.
- done  output  1  one-cycle pulse; results valid from this cycle.
- quotient  output  WIDTH  signed quotient, truncated toward zero.
- remainder  output  WIDTH  signed remainder; sign follows dividend; |remainder| < |divisor|.
- div_by_zero  output  1  result flag: divisor was 0.
- overflow  output  1  result flag: dividend = -2^(WIDTH-1) and divisor = -1.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, ready=1, done=0, quotient=0, remainder=0, div_by_zero=0, overflow=0, all internal registers cleared. Asserting rst_n low mid-operation aborts the division with no done pulse.
- State machine: IDLE -> CALC -> FIX -> DONE -> IDLE.
- IDLE:
  - start=1 at edge T: capture sign_q = sign(dividend) XOR sign(divisor), sign_r = sign(dividend).
  - Capture unsigned magnitudes |dividend| and |divisor| as WIDTH-bit unsigned values; |-2^(WIDTH-1)| = 2^(WIDTH-1) fits.
  - Clear the WIDTH+1-bit partial remainder, load the iteration counter with WIDTH, go to CALC.
- CALC (exactly WIDTH cycles):
  - Each cycle, shift {partial remainder, dividend magnitude} left by 1.
  - Trial-subtract the divisor magnitude. If the result is non-negative, keep it and shift in quotient bit 1; otherwise restore and shift in 0.
  - Decrement the counter; after the WIDTH-th iteration go to FIX.
- FIX (1 cycle): negate the quotient magnitude if sign_q=1 and the remainder magnitude if sign_r=1, both modulo 2^WIDTH. Register the results into quotient/remainder and set the flags. Go to DONE.
- DONE (1 cycle): done=1, ready=0; next state IDLE.
- Latency: start accepted at edge T -> done=1 in cycle T+WIDTH+2. Issue interval is WIDTH+3 cycles.
- Outputs and flags hold their values from DONE until the FIX cycle of the next division overwrites them.
- start while ready=0 is ignored, including during DONE; no queuing. Operands on dividend/divisor are don't-care except at the accepted edge.
- Divide by zero: fixed latency is kept. Result is quotient = all ones (-1), remainder = dividend, div_by_zero=1, overflow=0.
- Overflow case (-2^(WIDTH-1) / -1): quotient = -2^(WIDTH-1) (wrapped), remainder=0, overflow=1, div_by_zero=0.
- Normal results clear both flags.
- Zero dividend with nonzero divisor: quotient=0, remainder=0 (no negative zero issue; negation of 0 is 0).

Test Plan (WIDTH=8):
- Reset, then start with 100 / 7 -> done exactly 10 cycles after the accepted edge; quotient=14, remainder=2, both flags 0; ready low from T+1 until after done.
- -100 / 7 -> quotient=-14 (0xF2), remainder=-2 (0xFE); 100 / -7 -> quotient=-14, remainder=2; -100 / -7 -> quotient=14, remainder=-2.
- -128 / -1 -> quotient=-128 (0x80), remainder=0, overflow=1; then -128 / 1 -> quotient=-128, overflow=0. Also 127 / 127 -> quotient=1, remainder=0.
- 5 / 0 -> done after 10 cycles, quotient=0xFF, remainder=5, div_by_zero=1; following 9 / 3 -> quotient=3, remainder=0, div_by_zero=0.
- Start 100 / 7, then pulse start with 50 / 5 at cycles T+3 and at the DONE cycle -> both ignored; only one done pulse, with 14 r 2; a subsequent start accepted in IDLE gives 10 r 0.
- Start 100 / 7, drop rst_n at T+4 -> outputs clear immediately, no done pulse, ready=1 after release; a fresh 20 / 6 gives 3 r 2.
